// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM state type and RAM geometry.
package dmem_pkg;

  localparam int RAM_ADDR_W = 11;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WRITE  = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Size code 3 is an alias of word.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'd3);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load byte/half extract with sign/zero extension, and store lane merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [15:0] low_s;

  // Shift the addressed lane down to bit 0, then extend or merge by size.
  always_comb begin
    low_s      = 16'(rd_data >> {offset, 3'b000});
    load_data  = rd_data;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & low_s[7]}}, low_s[7:0]};
        case (offset)
          2'd0:    merge_data = {rd_data[31:8], wdata[7:0]};
          2'd1:    merge_data = {rd_data[31:16], wdata[7:0], rd_data[7:0]};
          2'd2:    merge_data = {rd_data[31:24], wdata[7:0], rd_data[15:0]};
          2'd3:    merge_data = {wdata[7:0], rd_data[23:0]};
          default: merge_data = rd_data;
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & low_s[15]}}, low_s[15:0]};
        if (offset[1]) begin
          merge_data = {wdata[15:0], rd_data[15:0]};
        end else begin
          merge_data = {rd_data[31:16], wdata[15:0]};
        end
      end
      default: begin
        load_data  = rd_data;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller over an async-read word RAM.
// Define DMEM_MISALIGN_EXC_EN to report misaligned half/word accesses via resp_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [31:0]       ram_wr_data,
  input  logic [31:0]       ram_rd_data
);

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [1:0]        offset_s;
  logic              misalign_s;
  logic [31:0]       load_data_s;
  logic [31:0]       merge_data_s;
  logic              unused_s;

  assign unused_s = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_EXC_EN
  assign misalign_s = ((size_q == SZ_HALF) && addr_q[0]) ||
                      (is_word(size_q) && (addr_q[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Effective lane offset: low bits that would misalign the access are forced to zero.
  always_comb begin
    case (size_q)
      SZ_BYTE: offset_s = addr_q[1:0];
      SZ_HALF: offset_s = {addr_q[1], 1'b0};
      default: offset_s = 2'b00;
    endcase
  end

  dmem_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (offset_s),
    .wdata       (wdata_q),
    .rd_data     (ram_rd_data),
    .load_data   (load_data_s),
    .merge_data  (merge_data_s)
  );

  // Next-state and response computation.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = misalign_s;
        resp_rdata_d = 32'd0;
        if (misalign_s) begin
          state_d = ST_RESP;
        end else if (!wr_q) begin
          resp_rdata_d = load_data_s;
          state_d      = ST_RESP;
        end else if (is_word(size_q)) begin
          state_d = ST_RESP;
        end else begin
          resp_valid_d = 1'b0;
          merge_d      = merge_data_s;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      merge_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = addr_q[ADDR_W+1:2];

  // Gated by resetn so a reset landing on a write cycle never reaches the RAM.
  assign ram_wr_en = resetn &&
                     (((state_q == ST_ACCESS) && wr_q && is_word(size_q) && !misalign_s) ||
                      (state_q == ST_WRITE));
  assign ram_wr_data = (state_q == ST_WRITE) ? merge_q : wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level reference model, per-cycle monitor, directed and random accesses.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [10:0] ram_addr;
  logic        ram_wr_en;
  logic [31:0] ram_wr_data, ram_rd_data;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count;
  logic [31:0] exp_rdata, exp_word, last_rdata;
  logic        exp_err, last_err;
  logic [10:0] exp_idx, last_seen;
  int          last_lat;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_addr     (ram_addr),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_data  (ram_rd_data)
  );

  assign ram_rd_data = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    mem[idx]     <= val;
    ref_mem[idx]  = val;
  endtask

  // Reference: what one access must return and leave in memory.
  task automatic model(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] old,
                       output logic [31:0] rd, output logic err, output logic [31:0] nw, output int lat);
    logic [1:0]  off;
    logic [31:0] mask, lane;
    int          sh;
    err = 1'b0;
    case (size)
      2'd0:    off = addr[1:0];
      2'd1:    off = {addr[1], 1'b0};
      default: off = 2'd0;
    endcase
`ifdef DMEM_MISALIGN_EXC_EN
    if (size == 2'd1 && addr[0]) err = 1'b1;
    if (size >= 2'd2 && addr[1:0] != 2'd0) err = 1'b1;
`endif
    sh   = 8 * int'(off);
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    lane = (old >> sh) & mask;
    if (!uns && size == 2'd0 && lane[7])  lane = lane | 32'hFFFFFF00;
    if (!uns && size == 2'd1 && lane[15]) lane = lane | 32'hFFFF0000;
    rd  = (wr || err) ? 32'd0 : lane;
    nw  = (old & ~(mask << sh)) | ((wdata & mask) << sh);
    lat = (wr && !err && size < 2'd2) ? 3 : 2;
  endtask

  // Per-cycle monitor: response values, write traffic and reset gating.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("wr_en_in_reset", {31'd0, ram_wr_en}, 32'd0);
    end else begin
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
      if (ram_wr_en) begin
        wr_count++;
        chk("ram_addr_on_write", {21'd0, ram_addr}, {21'd0, exp_idx});
        chk("ram_wr_data", ram_wr_data, exp_word);
      end
    end
  end

  // One full access; called at #1 after a rising edge with the DUT idle.
  task automatic do_txn(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [10:0] idx;
    logic [31:0] rd, nw;
    logic        err, v;
    int          lat, n;
    idx = addr[12:2];
    model(wr, size, uns, addr, wdata, ref_mem[idx], rd, err, nw, lat);
    exp_rdata = rd; exp_err = err; exp_idx = idx; exp_word = nw; wr_count = 0;
    req_wr = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; v = 1'b0; last_seen = '0;
    while (!v && n < 10) begin
      @(negedge clk);
      v = resp_valid;
      if (n == 0) last_seen = ram_addr;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("ram_addr_access", {21'd0, last_seen}, {21'd0, idx});
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("wr_pulses", wr_count, (wr && !err) ? 32'd1 : 32'd0);
    if (wr && !err) ref_mem[idx] = nw;
    last_lat = n;
  endtask

  initial begin
    logic [31:0] a;
    int          bad;
    resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_wr = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    exp_rdata = 32'd0; exp_err = 1'b0; exp_idx = '0; exp_word = 32'd0;
    wr_count = 0; last_rdata = 32'd0; last_err = 1'b0; last_seen = '0; last_lat = 0;
    for (int i = 0; i < 2048; i++) poke(i, $urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Signed byte load from a known word.
    poke(5, 32'h8899AABB);
    do_txn(1'b0, 2'd0, 1'b0, 32'h15, 32'd0, 0);
    chk("pin_lb_signed", last_rdata, 32'hFFFFFFAA);
    chk("pin_lb_lat", last_lat, 32'd2);

    // Half store into the upper lane, merged over existing bytes.
    do_txn(1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234, 0);
    chk("pin_sh_merge", mem[5], 32'h1234AABB);
    chk("pin_sh_lat", last_lat, 32'd3);

    // Top word of RAM, then an address that wraps to word 0.
    do_txn(1'b1, 2'd2, 1'b0, 32'h1FFC, 32'hDEADBEEF, 0);
    chk("pin_top_addr", {21'd0, last_seen}, 32'h7FF);
    chk("pin_top_data", mem[11'h7FF], 32'hDEADBEEF);
    chk("pin_ws_lat", last_lat, 32'd2);
    poke(0, 32'hCAFEF00D);
    do_txn(1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 0);
    chk("pin_wrap_addr", {21'd0, last_seen}, 32'd0);
    chk("pin_wrap_data", last_rdata, 32'hCAFEF00D);

    // Response held back for four cycles.
    do_txn(1'b0, 2'd1, 1'b1, 32'h16, 32'd0, 4);
    chk("pin_lhu", last_rdata, 32'h00001234);

    // Misaligned word load.
    poke(4, 32'h01020304);
    do_txn(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, 0);
`ifdef DMEM_MISALIGN_EXC_EN
    chk("pin_mis_err", {31'd0, last_err}, 32'd1);
    chk("pin_mis_rdata", last_rdata, 32'd0);
`else
    chk("pin_mis_err", {31'd0, last_err}, 32'd0);
    chk("pin_mis_rdata", last_rdata, 32'h01020304);
`endif

    // Reset asserted during the WRITE cycle of a byte store.
    poke(8, 32'h55667788);
    exp_idx = 11'd8; exp_word = 32'h556677AB; wr_count = 0;
    req_wr = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h000000AB;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_en_in_write", {31'd0, ram_wr_en}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("wr_en_dropped", {31'd0, ram_wr_en}, 32'd0);
    @(posedge clk); #1;
    chk("rst2_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst2_resp_rdata", resp_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset2", {31'd0, req_ready}, 32'd1);
    chk("rst2_no_write", mem[8], 32'h55667788);
    chk("rst2_wr_pulses", wr_count, 32'd0);
    @(posedge clk); #1;

    // Random accesses concentrated on 16 words; high address bits must be ignored.
    for (int t = 0; t < 300; t++) begin
      a = $urandom & 32'hFFFFE03F;
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 2));
    end

    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    chk("mem_final_mismatches", bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
